// File: rtl/cache_sa_ctrl.sv
// N-way set-associative cache controller for the MIPS64 load/store path.
// Reads allocate on miss via a memory refill. Writes go straight through to
// memory and update the cache only on a hit, so a write miss never allocates.
// Replacement uses the lowest invalid way first, then a per-set round-robin
// pointer. Hit and miss counters saturate instead of wrapping.
module cache_sa_ctrl #(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_BYTES = 8,
  parameter int ADDR_L     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_L-1:0]       addr,
  input  logic [8*LINE_BYTES-1:0] wdata,
  input  logic [LINE_BYTES-1:0]   be,
  input  logic                    flush,
  output logic                    busy,
  output logic                    done,
  output logic [8*LINE_BYTES-1:0] rdata,
  output logic                    hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_L-1:0]       mem_addr,
  output logic [8*LINE_BYTES-1:0] mem_wdata,
  output logic [LINE_BYTES-1:0]   mem_be,
  input  logic                    mem_ack,
  input  logic [8*LINE_BYTES-1:0] mem_rdata,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int OB = $clog2(LINE_BYTES);
  localparam int IB = $clog2(SETS);
  localparam int TW = ADDR_L - OB - IB;
  localparam int DW = 8 * LINE_BYTES;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_L-1:0] ALIGN_MASK = {ADDR_L{1'b1}} << OB;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, WTHRU} state_t;

  state_t state;

  // Request captured at accept time; the pipeline may change its inputs afterwards.
  logic                  lat_we;
  logic [ADDR_L-1:0]     lat_addr;
  logic [DW-1:0]         lat_wdata;
  logic [LINE_BYTES-1:0] lat_be;
  logic                  lat_hit;

  // Valid bits and round-robin pointers are reset. Tags and data are not.
  logic [SETS-1:0] valid   [WAYS];
  logic [WW-1:0]   rr      [SETS];
  logic [TW-1:0]   tag_arr [WAYS][SETS];
  logic [DW-1:0]   data_arr[WAYS][SETS];

  logic [IB-1:0] lat_idx;
  logic [TW-1:0] lat_tag;
  logic          hit_any;
  logic [WW-1:0] hit_way;
  logic          inv_any;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] victim;
  logic [DW-1:0] merged;
  logic          fill_en;
  logic          merge_en;

  assign lat_idx = lat_addr[OB+IB-1:OB];
  assign lat_tag = lat_addr[ADDR_L-1:OB+IB];

  // Tag match across all ways of the latched set, plus victim selection and write-hit byte merge.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][lat_idx] && (tag_arr[w][lat_idx] == lat_tag)) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid[w][lat_idx] && !inv_any) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
    victim = inv_any ? inv_way : rr[lat_idx];
    merged = data_arr[hit_way][lat_idx];
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (lat_be[b]) begin
        merged[8*b +: 8] = lat_wdata[8*b +: 8];
      end
    end
  end

  assign merge_en = (state == LOOKUP) && lat_we && hit_any;
  assign fill_en  = (state == REFILL) && mem_req && mem_ack;

  // Tag and data storage. Writes only happen on refill completion or on a write hit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (merge_en) begin
        data_arr[hit_way][lat_idx] <= merged;
      end
      if (fill_en) begin
        data_arr[victim][lat_idx] <= mem_rdata;
        tag_arr[victim][lat_idx]  <= lat_tag;
      end
    end
  end

  // Control FSM with registered outputs, valid/replacement bookkeeping and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_hit   <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) begin
        rr[s] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            for (int w = 0; w < WAYS; w++) begin
              valid[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) begin
              rr[s] <= '0;
            end
          end else if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_be    <= be;
            busy      <= 1'b1;
            state     <= LOOKUP;
          end
        end

        LOOKUP: begin
          lat_hit <= hit_any;
          if (hit_any) begin
            if (hit_cnt != {CNT_W{1'b1}}) begin
              hit_cnt <= hit_cnt + 1'b1;
            end
          end else begin
            if (miss_cnt != {CNT_W{1'b1}}) begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          if (lat_we) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= lat_addr & ALIGN_MASK;
            mem_wdata <= lat_wdata;
            mem_be    <= lat_be;
            state     <= WTHRU;
          end else if (hit_any) begin
            rdata <= data_arr[hit_way][lat_idx];
            hit   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= lat_addr & ALIGN_MASK;
            state    <= REFILL;
          end
        end

        REFILL: begin
          if (mem_req && mem_ack) begin
            valid[victim][lat_idx] <= 1'b1;
            if ((WAYS > 1) && !inv_any) begin
              rr[lat_idx] <= rr[lat_idx] + 1'b1;
            end
            rdata   <= mem_rdata;
            hit     <= 1'b0;
            done    <= 1'b1;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        WTHRU: begin
          if (mem_req && mem_ack) begin
            hit     <= lat_hit;
            done    <= 1'b1;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sa_ctrl.sv
// Self-checking bench for cache_sa_ctrl: directed scenarios followed by random
// traffic, all compared against a line-level cache model kept in this file.
module tb_cache_sa_ctrl;

  localparam int WAYS = 2;
  localparam int SETS = 32;
  localparam int CNT_W = 6;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] rdata;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int errors = 0;
  int checks = 0;

  // Cache model: one entry per way and set, plus replacement pointers and counters.
  bit          m_valid[WAYS][SETS];
  int unsigned m_tag  [WAYS][SETS];
  logic [63:0] m_data [WAYS][SETS];
  int          m_rr   [SETS];
  int          m_hits;
  int          m_misses;
  logic [63:0] m_rdata;

  // Values captured during the most recent transaction.
  logic [31:0] cap_mem_addr;

  cache_sa_ctrl #(
    .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(8), .ADDR_L(32), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .flush(flush), .busy(busy), .done(done),
    .rdata(rdata), .hit(hit), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelFlush();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
  endtask

  task automatic modelReset();
    modelFlush();
    m_hits = 0;
    m_misses = 0;
    m_rdata = '0;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hit_cnt"}, 64'(hit_cnt), 64'(m_hits));
    checkOutput({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(m_misses));
  endtask

  // One complete request: model prediction, drive, serve memory, compare.
  task automatic applyStimulus(input logic t_we, input logic [31:0] t_addr,
                               input logic [63:0] t_wdata, input logic [7:0] t_be,
                               input int t_delay, input logic [63:0] t_fill);
    int s, h, v, cycles, wait_cnt;
    int unsigned tg;
    logic exp_hit, exp_mem, got_done, mem_seen;
    logic cap_hit, cap_we, cap_busy;
    logic [7:0] cap_be;
    logic [63:0] cap_wdata;

    s = int'((t_addr >> 3) % SETS);
    tg = t_addr >> 8;
    h = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][s] && m_tag[w][s] == tg) h = w;
    exp_hit = (h >= 0);
    exp_mem = t_we || !exp_hit;
    if (exp_hit) m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
    else m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
    if (!t_we) begin
      if (exp_hit) m_rdata = m_data[h][s];
      else begin
        v = -1;
        for (int w = 0; w < WAYS; w++)
          if (!m_valid[w][s] && v < 0) v = w;
        if (v < 0) begin
          v = m_rr[s];
          m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_valid[v][s] = 1'b1;
        m_tag[v][s] = tg;
        m_data[v][s] = t_fill;
        m_rdata = t_fill;
      end
    end else if (exp_hit) begin
      for (int b = 0; b < 8; b++)
        if (t_be[b]) m_data[h][s][8*b +: 8] = t_wdata[8*b +: 8];
    end

    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; be = t_be;
    cycles = 0; wait_cnt = 0; got_done = 1'b0; mem_seen = 1'b0;
    cap_hit = 1'b0; cap_we = 1'b0; cap_be = '0; cap_wdata = '0; cap_busy = 1'b0;
    while (!got_done && cycles < 50) begin
      @(negedge clk);
      cycles++;
      req = 1'b0;
      mem_ack = 1'b0;
      if (cycles == 1) cap_busy = busy;
      if (done) begin
        got_done = 1'b1;
        cap_hit = hit;
      end else if (mem_req) begin
        if (!mem_seen) begin
          mem_seen = 1'b1;
          cap_mem_addr = mem_addr;
          cap_we = mem_we;
          cap_be = mem_be;
          cap_wdata = mem_wdata;
        end
        if (wait_cnt == t_delay) begin
          mem_ack = 1'b1;
          mem_rdata = t_fill;
        end
        wait_cnt++;
      end
    end
    mem_ack = 1'b0;

    checkOutput("busy_after_accept", 64'(cap_busy), 64'd1);
    checkOutput("done_seen", 64'(got_done), 64'd1);
    checkOutput("hit", 64'(cap_hit), 64'(exp_hit));
    checkOutput("rdata", rdata, m_rdata);
    checkOutput("mem_req_issued", 64'(mem_seen), 64'(exp_mem));
    if (exp_mem) begin
      checkOutput("mem_addr", 64'(cap_mem_addr), 64'(t_addr & 32'hFFFF_FFF8));
      checkOutput("mem_we", 64'(cap_we), 64'(t_we));
      if (t_we) begin
        checkOutput("mem_be", 64'(cap_be), 64'(t_be));
        checkOutput("mem_wdata", cap_wdata, t_wdata);
      end
    end else begin
      checkOutput("hit_latency", 64'(cycles), 64'd2);
    end
    checkCounters("xact");
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    modelReset();
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_rdata", rdata, 64'd0);
    checkCounters("rst");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    int steps;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    resetDut();

    $display("[TB] miss refill and re-read hit");
    applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 3, 64'hA5A5_A5A5_A5A5_A5A5);
    checkOutput("t1_mem_addr", 64'(cap_mem_addr), 64'h100);
    checkOutput("t1_rdata", rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 0, 64'd0);
    checkOutput("t1_hit_cnt", 64'(hit_cnt), 64'd1);

    $display("[TB] replacement within set 0");
    applyStimulus(1'b0, 32'h200, 64'd0, 8'h00, 1, 64'h2222_2222_2222_2222);
    applyStimulus(1'b0, 32'h300, 64'd0, 8'h00, 2, 64'h3333_3333_3333_3333);
    applyStimulus(1'b0, 32'h200, 64'd0, 8'h00, 0, 64'd0);
    applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 0, 64'hA5A5_A5A5_A5A5_A5A5);

    $display("[TB] write hit byte merge");
    applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 0, 64'd0);
    applyStimulus(1'b1, 32'h100, 64'hFF, 8'h01, 2, 64'd0);
    applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 0, 64'd0);
    checkOutput("t3_merged", rdata, 64'hA5A5_A5A5_A5A5_A5FF);

    $display("[TB] write miss does not allocate");
    applyStimulus(1'b1, 32'h400, 64'h1234_5678_9ABC_DEF0, 8'hF0, 1, 64'd0);
    applyStimulus(1'b0, 32'h400, 64'd0, 8'h00, 0, 64'h4444_4444_4444_4444);

    $display("[TB] flush in idle, and flush together with req");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    modelFlush();
    checkOutput("flush_busy", 64'(busy), 64'd0);
    applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 1, 64'h5555_6666_7777_8888);
    req = 1'b1; flush = 1'b1; we = 1'b0; addr = 32'h100;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    modelFlush();
    checkOutput("reqflush_busy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("reqflush_done", 64'(done), 64'd0);
    checkOutput("reqflush_mem_req", 64'(mem_req), 64'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("idle_ack_busy", 64'(busy), 64'd0);
    checkOutput("idle_ack_done", 64'(done), 64'd0);
    checkCounters("idle_ack");
    applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 0, 64'h9999_AAAA_BBBB_CCCC);

    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        modelFlush();
      end
      ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 3) | $urandom_range(0, 7);
      applyStimulus(1'($urandom_range(0, 1)), ra, {$urandom, $urandom},
                    8'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    {$urandom, $urandom});
    end

    $display("[TB] reset during refill");
    req = 1'b1; we = 1'b0; addr = 32'h800;
    @(negedge clk);
    req = 1'b0;
    steps = 0;
    while (!mem_req && steps < 10) begin
      @(negedge clk);
      steps++;
    end
    checkOutput("midrst_in_refill", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    checkOutput("midrst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkCounters("midrst");
    mem_ack = 1'b1;
    mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("late_ack_busy", 64'(busy), 64'd0);
    checkOutput("late_ack_done", 64'(done), 64'd0);
    checkOutput("late_ack_rdata", rdata, 64'd0);
    checkCounters("late_ack");

    $display("[TB] hit counter saturation");
    applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 0, 64'h0102_0304_0506_0708);
    for (int i = 0; i < CMAX + 4; i++)
      applyStimulus(1'b0, 32'h100, 64'd0, 8'h00, 0, 64'd0);
    checkOutput("hit_cnt_saturated", 64'(hit_cnt), 64'(CMAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
